// File: rtl/board_io_frontend.sv
// -----------------------------------------------------------------------------
// board_io_frontend
//
// Board-level GPIO front-end sitting between raw FPGA pins and the SoC GPIO
// ports.
//
// Input path, per channel:
//   pin -> two-flop synchroniser -> polarity fix -> debounce -> SoC gpio_i
//   The debounce stage also produces one-cycle rise and fall event pulses.
//
// Output path:
//   SoC gpio_o bits -> AND with a shared PWM "on" flag -> registered LED pins.
//   The PWM duty is captured only at period boundaries, so brightness changes
//   never glitch within a period.
//
// Ports:
//   clk_i       sole clock; all state changes on its rising edge
//   rst_i       asynchronous, active-high reset
//   pin_i       [NumIn]      raw asynchronous pin levels
//   soc_gpio_o  [GpioWidth]  debounced levels, zero-extended, to SoC gpio_i
//   rise_o      [NumIn]      one-cycle pulse on a debounced 0->1 change
//   fall_o      [NumIn]      one-cycle pulse on a debounced 1->0 change
//   soc_gpio_i  [GpioWidth]  SoC gpio_o; only bits [NumOut-1:0] are used
//   duty_i      [PwmBits]    LED brightness (all-ones = fully on)
//   led_o       [NumOut]     LED pin drive, active-high
// -----------------------------------------------------------------------------
module board_io_frontend #(
    parameter int unsigned       NumIn          = 3,
    parameter int unsigned       NumOut         = 5,
    parameter int unsigned       GpioWidth      = 32,
    parameter int unsigned       DebounceCycles = 6000,
    parameter int unsigned       PwmBits        = 8,
    parameter logic [NumIn-1:0]  InvertIn       = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumIn-1:0]     pin_i,
    output logic [GpioWidth-1:0] soc_gpio_o,
    output logic [NumIn-1:0]     rise_o,
    output logic [NumIn-1:0]     fall_o,
    input  logic [GpioWidth-1:0] soc_gpio_i,
    input  logic [PwmBits-1:0]   duty_i,
    output logic [NumOut-1:0]    led_o
);

    // Parameter sanity: reject out-of-range configurations at elaboration.
    if (NumIn < 1 || NumIn > GpioWidth || NumOut < 1 || NumOut > GpioWidth ||
        DebounceCycles < 1 || PwmBits < 1) begin : g_param_error
        $error("board_io_frontend: parameter out of range");
    end

    localparam int unsigned      CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(DebounceCycles - 1);

    // -------------------------------------------------------------------------
    // Synchroniser and polarity correction
    // -------------------------------------------------------------------------
    logic [NumIn-1:0] s1;
    logic [NumIn-1:0] s2;
    logic [NumIn-1:0] sample;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its source, as real hardware does.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_i;
            s2 <= s1;
        end
    end

    // Active-low channels are flipped here so everything downstream is active-high.
    assign sample = s2 ^ InvertIn;

    // -------------------------------------------------------------------------
    // Debounce: a change is accepted only after DebounceCycles consecutive
    // differing samples; any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    logic [NumIn-1:0] stable;
    logic [CntW-1:0]  cnt [NumIn];
    logic [NumIn-1:0] rise_q;
    logic [NumIn-1:0] fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable <= '0;
            rise_q <= '0;
            fall_q <= '0;
            // NOTE: the counter array is a handful of registers, not a RAM, and a
            // reset mid-debounce must discard partial counts, so it is reset here.
            for (int i = 0; i < NumIn; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (sample[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntMax) begin
                    // Accept the change; the event pulse lands in the same cycle
                    // as the new level.
                    stable[i] <= sample[i];
                    cnt[i]    <= '0;
                    rise_q[i] <= sample[i];
                    fall_q[i] <= ~sample[i];
                end else begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end
            end
        end
    end

    assign soc_gpio_o = GpioWidth'(stable);
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

    // -------------------------------------------------------------------------
    // PWM brightness
    // -------------------------------------------------------------------------
    logic [PwmBits-1:0] pcnt;
    logic [PwmBits-1:0] duty_q;
    logic               pwm_on;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt   <= '0;
            duty_q <= '0;
        end else begin
            pcnt <= pcnt + PwmBits'(1);
            // Duty is only captured on the last cycle of a period, so a new
            // value always starts at a period boundary.
            if (pcnt == '1) begin
                duty_q <= duty_i;
            end
        end
    end

    // All-ones is special-cased so full brightness has no dark cycle per period.
    assign pwm_on = (duty_q == '1) || (pcnt < duty_q);

    // -------------------------------------------------------------------------
    // LED stage
    // -------------------------------------------------------------------------
    logic [NumOut-1:0]    led_q;
    logic [GpioWidth-1:0] unused_soc_gpio;

    // Upper SoC output bits have no LED attached.
    assign unused_soc_gpio = soc_gpio_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= '0;
        end else begin
            led_q <= soc_gpio_i[NumOut-1:0] & {NumOut{pwm_on}};
        end
    end

    assign led_o = led_q;

endmodule

// File: tb/tb_board_io_frontend.sv
// -----------------------------------------------------------------------------
// tb_board_io_frontend
//
// Directed bench for board_io_frontend. Two instances share clock and reset:
//   u_dut    : InvertIn = 3'b000 (clean press, bounce, PWM, reset mid-run)
//   u_dut_al : InvertIn = 3'b101 (active-low channels, simultaneous edges)
// Both use DebounceCycles = 4 and PwmBits = 4. Inputs change 1 time unit after
// a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_board_io_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [2:0]  pin_a = 3'b000;
    logic [31:0] soc_a;
    logic [2:0]  rise_a;
    logic [2:0]  fall_a;
    logic [31:0] gpio_in_a = 32'h0000_001F;
    logic [3:0]  duty_a = 4'd0;
    logic [4:0]  led_a;

    logic [2:0]  pin_b = 3'b101;
    logic [31:0] soc_b;
    logic [2:0]  rise_b;
    logic [2:0]  fall_b;
    logic [31:0] gpio_in_b = 32'h0;
    logic [3:0]  duty_b = 4'd0;
    logic [4:0]  led_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    board_io_frontend #(
        .NumIn(3), .NumOut(5), .GpioWidth(32), .DebounceCycles(4),
        .PwmBits(4), .InvertIn(3'b000)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .pin_i(pin_a), .soc_gpio_o(soc_a),
        .rise_o(rise_a), .fall_o(fall_a), .soc_gpio_i(gpio_in_a),
        .duty_i(duty_a), .led_o(led_a)
    );

    board_io_frontend #(
        .NumIn(3), .NumOut(5), .GpioWidth(32), .DebounceCycles(4),
        .PwmBits(4), .InvertIn(3'b101)
    ) u_dut_al (
        .clk_i(clk), .rst_i(rst), .pin_i(pin_b), .soc_gpio_o(soc_b),
        .rise_o(rise_b), .fall_o(fall_b), .soc_gpio_i(gpio_in_b),
        .duty_i(duty_b), .led_o(led_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        #12;
        n_checks++; if (soc_a !== 32'h0) begin n_fail++; $display("FAIL reset soc_gpio_o: got %h expected %h", soc_a, 32'h0); end
        n_checks++; if (rise_a !== 3'b000) begin n_fail++; $display("FAIL reset rise_o: got %b expected %b", rise_a, 3'b000); end
        n_checks++; if (fall_a !== 3'b000) begin n_fail++; $display("FAIL reset fall_o: got %b expected %b", fall_a, 3'b000); end
        n_checks++; if (led_a !== 5'h00) begin n_fail++; $display("FAIL reset led_o: got %h expected %h", led_a, 5'h00); end
        n_checks++; if (soc_b !== 32'h0) begin n_fail++; $display("FAIL reset al soc_gpio_o: got %h expected %h", soc_b, 32'h0); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Active-low pins idle high give level 0 and no events; then pins 0 and 2
    // drop together and both rise in one cycle.
    task automatic test_active_low();
        logic [31:0] exp_soc;
        logic [2:0]  exp_rise;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (soc_b !== 32'h0) begin n_fail++; $display("FAIL al_idle soc cycle %0d: got %h expected %h", i, soc_b, 32'h0); end
            n_checks++; if (rise_b !== 3'b000 || fall_b !== 3'b000) begin n_fail++; $display("FAIL al_idle pulses cycle %0d: got rise %b fall %b expected 000", i, rise_b, fall_b); end
        end
        pin_b = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_soc  = (i >= 6) ? 32'h5 : 32'h0;
            exp_rise = (i == 6) ? 3'b101 : 3'b000;
            n_checks++; if (soc_b !== exp_soc) begin n_fail++; $display("FAIL al_edge soc cycle %0d: got %h expected %h", i, soc_b, exp_soc); end
            n_checks++; if (rise_b !== exp_rise) begin n_fail++; $display("FAIL al_edge rise cycle %0d: got %b expected %b", i, rise_b, exp_rise); end
            n_checks++; if (fall_b !== 3'b000) begin n_fail++; $display("FAIL al_edge fall cycle %0d: got %b expected 000", i, fall_b); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Pin 0 rises and holds: level and rise pulse appear 6 edges later.
    task automatic test_clean_press();
        logic [31:0] exp_soc;
        logic [2:0]  exp_rise;
        pin_a = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_soc  = (i >= 6) ? 32'h1 : 32'h0;
            exp_rise = (i == 6) ? 3'b001 : 3'b000;
            n_checks++; if (soc_a !== exp_soc) begin n_fail++; $display("FAIL clean_press soc cycle %0d: got %h expected %h", i, soc_a, exp_soc); end
            n_checks++; if (rise_a !== exp_rise) begin n_fail++; $display("FAIL clean_press rise cycle %0d: got %b expected %b", i, rise_a, exp_rise); end
            n_checks++; if (fall_a !== 3'b000) begin n_fail++; $display("FAIL clean_press fall cycle %0d: got %b expected 000", i, fall_a); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Pin 1: high 3 edges, low 1, then high. Only the final run is accepted,
    // giving a single rise at edge 10.
    task automatic test_bounce();
        logic [2:0]  exp_rise;
        logic [31:0] exp_soc;
        for (int i = 1; i <= 16; i++) begin
            pin_a[1] = (i == 4) ? 1'b0 : 1'b1;
            tick();
            exp_rise = (i == 10) ? 3'b010 : 3'b000;
            exp_soc  = (i >= 10) ? 32'h3 : 32'h1;
            n_checks++; if (rise_a !== exp_rise) begin n_fail++; $display("FAIL bounce rise cycle %0d: got %b expected %b", i, rise_a, exp_rise); end
            n_checks++; if (fall_a !== 3'b000) begin n_fail++; $display("FAIL bounce fall cycle %0d: got %b expected 000", i, fall_a); end
            n_checks++; if (soc_a !== exp_soc) begin n_fail++; $display("FAIL bounce soc cycle %0d: got %h expected %h", i, soc_a, exp_soc); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Counts lit samples over a window; also flags values other than 0 / 0x1F.
    task automatic count_lit(input int n, output int lit, output int bad);
        lit = 0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led_a === 5'h1F) lit++;
            else if (led_a !== 5'h00) bad++;
        end
    endtask

    task automatic test_pwm();
        int lit;
        int bad;
        bit found;
        logic [4:0] prev;

        duty_a = 4'd5;
        repeat (20) tick();
        count_lit(32, lit, bad);
        n_checks++; if (lit !== 10) begin n_fail++; $display("FAIL pwm_duty5 lit cycles: got %0d expected %0d", lit, 10); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pwm_duty5 partial led values: got %0d expected %0d", bad, 0); end

        duty_a = 4'd0;
        repeat (20) tick();
        count_lit(32, lit, bad);
        n_checks++; if (lit !== 0 || bad !== 0) begin n_fail++; $display("FAIL pwm_duty0 lit cycles: got %0d (bad %0d) expected 0", lit, bad); end

        duty_a = 4'd15;
        repeat (20) tick();
        count_lit(32, lit, bad);
        n_checks++; if (lit !== 32) begin n_fail++; $display("FAIL pwm_duty15 lit cycles: got %0d expected %0d", lit, 32); end

        // Mid-period change: lock onto a period start, switch duty, and expect
        // the old duty to finish out the period.
        duty_a = 4'd5;
        repeat (20) tick();
        found = 1'b0;
        prev  = led_a;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev === 5'h00 && led_a === 5'h1F) found = 1'b1;
            prev = led_a;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL pwm_midchange period start: got none expected led rise within 40 cycles"); end
        duty_a = 4'd15;
        count_lit(15, lit, bad);
        n_checks++; if (lit !== 4) begin n_fail++; $display("FAIL pwm_midchange old period lit: got %0d expected %0d", lit, 4); end
        count_lit(16, lit, bad);
        n_checks++; if (lit !== 16) begin n_fail++; $display("FAIL pwm_midchange new period lit: got %0d expected %0d", lit, 16); end
    endtask

    // -------------------------------------------------------------------------
    // Reset two cycles before pin 2 would be accepted, with LEDs lit.
    task automatic test_reset_mid();
        logic [31:0] exp_soc;
        logic [2:0]  exp_rise;
        logic [4:0]  exp_led;
        pin_a = 3'b111;
        repeat (4) tick();
        n_checks++; if (soc_a !== 32'h3) begin n_fail++; $display("FAIL reset_mid pre soc: got %h expected %h", soc_a, 32'h3); end
        n_checks++; if (led_a !== 5'h1F) begin n_fail++; $display("FAIL reset_mid pre led: got %h expected %h", led_a, 5'h1F); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (soc_a !== 32'h0) begin n_fail++; $display("FAIL reset_mid async soc: got %h expected %h", soc_a, 32'h0); end
        n_checks++; if (led_a !== 5'h00) begin n_fail++; $display("FAIL reset_mid async led: got %h expected %h", led_a, 5'h00); end
        n_checks++; if (rise_a !== 3'b000 || fall_a !== 3'b000) begin n_fail++; $display("FAIL reset_mid async pulses: got rise %b fall %b expected 000", rise_a, fall_a); end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_rise = (i == 6) ? 3'b111 : 3'b000;
            exp_soc  = (i >= 6) ? 32'h7 : 32'h0;
            exp_led  = (i >= 17) ? 5'h1F : 5'h00;
            n_checks++; if (rise_a !== exp_rise) begin n_fail++; $display("FAIL reset_mid rise cycle %0d: got %b expected %b", i, rise_a, exp_rise); end
            n_checks++; if (fall_a !== 3'b000) begin n_fail++; $display("FAIL reset_mid fall cycle %0d: got %b expected 000", i, fall_a); end
            n_checks++; if (soc_a !== exp_soc) begin n_fail++; $display("FAIL reset_mid soc cycle %0d: got %h expected %h", i, soc_a, exp_soc); end
            n_checks++; if (led_a !== exp_led) begin n_fail++; $display("FAIL reset_mid led cycle %0d: got %h expected %h", i, led_a, exp_led); end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_active_low();
        test_clean_press();
        test_bounce();
        test_pwm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
